// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the IR/PC datapath, ALU,
// register file and unified memory.
interface multicycle_control_fsm_if #(
  parameter int INSTR_W = 32,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
);
  logic               stall;
  logic               mem_ready;
  logic [INSTR_W-1:0] instr;
  logic [2:0]         state;
  logic               ir_write;
  logic               pc_write;
  logic               pc_write_cond;
  logic               branch_ne;
  logic               jump;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         alu_src_b;
  logic               reg_dst;
  logic               reg_write;
  logic               mem_read;
  logic               mem_write;
  logic               mem_to_reg;
  logic               illegal_op;
  logic [CNT_W-1:0]   instr_count;

  // The control FSM side
  modport master (
    input  stall, mem_ready, instr,
    output state, ir_write, pc_write, pc_write_cond, branch_ne, jump, alu_op,
           alu_src_b, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
           illegal_op, instr_count
  );

  // The datapath side
  modport slave (
    output stall, mem_ready, instr,
    input  state, ir_write, pc_write, pc_write_cond, branch_ne, jump, alu_op,
           alu_src_b, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
           illegal_op, instr_count
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory
// ready handshake, stall freeze, illegal-opcode trap and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int INSTR_W  = 32,
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_control_fsm_if.master bus
);
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(9);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b111);

  logic [2:0]          state, nextState;
  logic [OPCODE_W-1:0] opcodeQ;
  logic [OPCODE_W-1:0] opcode;
  logic                illegalQ;
  logic [CNT_W-1:0]    count;
  logic                retire;
  logic irWr, pcWr, pcWrCond, jumpEn, regWr, memRd, memWr;

  assign opcode = bus.instr[INSTR_W-1 -: OPCODE_W];

  always_comb begin
    nextState = state;
    unique case (state)
      FETCH:  nextState = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (bus.instr == '0)         nextState = FETCH;
        else if (opcode > OP_J)      nextState = TRAP;
        else                         nextState = EXEC;
      end
      EXEC: begin
        case (opcodeQ)
          OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nextState = WB;
          OP_LW, OP_SW:                            nextState = MEM;
          default:                                 nextState = FETCH;
        endcase
      end
      MEM:     if (bus.mem_ready) nextState = (opcodeQ == OP_LW) ? WB : FETCH;
      WB:      nextState = FETCH;
      TRAP:    nextState = TRAP;
      default: nextState = FETCH;
    endcase
  end

  assign retire = (nextState == FETCH) &&
                  (state == DECODE || state == EXEC || state == MEM || state == WB);

  // A stall freezes every piece of architectural state, including a pending handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      opcodeQ  <= '0;
      illegalQ <= 1'b0;
      count    <= '0;
    end else if (!bus.stall) begin
      state <= nextState;
      if (state == DECODE) opcodeQ <= opcode;
      if (nextState == TRAP) illegalQ <= 1'b1;
      if (retire) count <= count + 1'b1;
    end
  end

  always_comb begin
    irWr = 1'b0; pcWr = 1'b0; pcWrCond = 1'b0; jumpEn = 1'b0;
    regWr = 1'b0; memRd = 1'b0; memWr = 1'b0;
    bus.branch_ne  = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.alu_src_b  = 2'd0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    case (state)
      FETCH: begin
        memRd = 1'b1;
        irWr  = 1'b1;
        pcWr  = bus.mem_ready;
        bus.alu_src_b = 2'd1;
      end
      EXEC: begin
        case (opcodeQ)
          OP_R:    bus.alu_op = ALU_FN;
          OP_ADDI: bus.alu_src_b = 2'd2;
          OP_ANDI: begin bus.alu_op = ALU_AND; bus.alu_src_b = 2'd2; end
          OP_ORI:  begin bus.alu_op = ALU_OR;  bus.alu_src_b = 2'd2; end
          OP_SLTI: begin bus.alu_op = ALU_SLT; bus.alu_src_b = 2'd2; end
          OP_LW, OP_SW: bus.alu_src_b = 2'd2;
          OP_BEQ, OP_BNE: begin
            bus.alu_op    = ALU_SUB;
            pcWrCond      = 1'b1;
            bus.branch_ne = (opcodeQ == OP_BNE);
          end
          OP_J: begin jumpEn = 1'b1; pcWr = 1'b1; end
          default: ;
        endcase
      end
      MEM: begin
        memRd = (opcodeQ == OP_LW);
        memWr = (opcodeQ == OP_SW);
      end
      WB: begin
        regWr          = 1'b1;
        bus.reg_dst    = (opcodeQ == OP_R);
        bus.mem_to_reg = (opcodeQ == OP_LW);
      end
      default: ;
    endcase
  end

  assign bus.ir_write      = irWr     & ~bus.stall;
  assign bus.pc_write      = pcWr     & ~bus.stall;
  assign bus.pc_write_cond = pcWrCond & ~bus.stall;
  assign bus.jump          = jumpEn   & ~bus.stall;
  assign bus.reg_write     = regWr    & ~bus.stall;
  assign bus.mem_read      = memRd    & ~bus.stall;
  assign bus.mem_write     = memWr    & ~bus.stall;
  assign bus.state         = state;
  assign bus.illegal_op    = illegalQ;
  assign bus.instr_count   = count;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected control vectors are
// queued as stimulus is driven and compared once the outputs settle.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic rst, rst4;
  int vectorCount = 0;
  int missCount   = 0;
  logic [15:0] expCount;

  typedef struct {
    string       tag;
    logic [18:0] ctrl;
    logic [15:0] cnt;
  } expect_t;
  expect_t scoreboard[$];

  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.INSTR_W(32), .ALUOP_W(3), .CNT_W(16)) bus ();
  multicycle_control_fsm_if #(.INSTR_W(32), .ALUOP_W(3), .CNT_W(4))  bus4 ();

  multicycle_control_fsm #(.INSTR_W(32), .OPCODE_W(6), .ALUOP_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  multicycle_control_fsm #(.INSTR_W(32), .OPCODE_W(6), .ALUOP_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4)
  );

  // Packs {state, ir,pc,pcCond,bne,jump, aluOp, srcB, dst,regWr,memRd,memWr,memToReg,illegal}
  function automatic logic [18:0] cv(input logic [2:0] st, input logic [4:0] pcBits,
                                     input logic [2:0] alu, input logic [1:0] srcB,
                                     input logic [5:0] wbBits);
    return {st, pcBits, alu, srcB, wbBits};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'h0ABCD};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sampleOutputs();
    expect_t e;
    logic [18:0] got;
    got = {bus.state, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.branch_ne,
           bus.jump, bus.alu_op, bus.alu_src_b, bus.reg_dst, bus.reg_write,
           bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.illegal_op};
    if (scoreboard.size() == 0) begin
      checkOutput("scoreboard-empty", 32'd1, 32'd0);
      return;
    end
    e = scoreboard.pop_front();
    checkOutput({e.tag, "-ctrl"}, {13'd0, got}, {13'd0, e.ctrl});
    checkOutput({e.tag, "-cnt"}, {16'd0, bus.instr_count}, {16'd0, e.cnt});
  endtask

  task automatic applyStimulus(input string tag, input logic rstV, input logic stallV,
                               input logic readyV, input logic [31:0] instrV,
                               input logic [18:0] ctrl);
    expect_t e;
    @(negedge clk);
    rst = rstV;
    bus.stall = stallV;
    bus.mem_ready = readyV;
    bus.instr = instrV;
    e.tag = tag; e.ctrl = ctrl; e.cnt = expCount;
    scoreboard.push_back(e);
    #1 sampleOutputs();
  endtask

  localparam logic [18:0] F_RDY   = cv(3'd0, 5'b11000, 3'b000, 2'd1, 6'b001000);
  localparam logic [18:0] F_WAIT  = cv(3'd0, 5'b10000, 3'b000, 2'd1, 6'b001000);
  localparam logic [18:0] F_STALL = cv(3'd0, 5'b00000, 3'b000, 2'd1, 6'b000000);
  localparam logic [18:0] DEC     = cv(3'd1, 5'b00000, 3'b000, 2'd0, 6'b000000);
  localparam logic [18:0] EX_R    = cv(3'd2, 5'b00000, 3'b010, 2'd0, 6'b000000);
  localparam logic [18:0] EX_MEM  = cv(3'd2, 5'b00000, 3'b000, 2'd2, 6'b000000);
  localparam logic [18:0] EX_BNE  = cv(3'd2, 5'b00110, 3'b001, 2'd0, 6'b000000);
  localparam logic [18:0] EX_BEQ  = cv(3'd2, 5'b00100, 3'b001, 2'd0, 6'b000000);
  localparam logic [18:0] EX_J    = cv(3'd2, 5'b01001, 3'b000, 2'd0, 6'b000000);
  localparam logic [18:0] MEM_LW  = cv(3'd3, 5'b00000, 3'b000, 2'd0, 6'b001000);
  localparam logic [18:0] MEM_SW  = cv(3'd3, 5'b00000, 3'b000, 2'd0, 6'b000100);
  localparam logic [18:0] MEM_HLD = cv(3'd3, 5'b00000, 3'b000, 2'd0, 6'b000000);
  localparam logic [18:0] WB_R    = cv(3'd4, 5'b00000, 3'b000, 2'd0, 6'b110000);
  localparam logic [18:0] WB_RSTL = cv(3'd4, 5'b00000, 3'b000, 2'd0, 6'b100000);
  localparam logic [18:0] WB_LW   = cv(3'd4, 5'b00000, 3'b000, 2'd0, 6'b010010);
  localparam logic [18:0] WB_I    = cv(3'd4, 5'b00000, 3'b000, 2'd0, 6'b010000);
  localparam logic [18:0] TRAPV   = cv(3'd5, 5'b00000, 3'b000, 2'd0, 6'b000001);

  // Hard stop in case something wedges the bench itself
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0]  iOps[4];
    logic [2:0]  iAlu[4];
    rst = 1'b1; rst4 = 1'b1;
    bus.stall = 1'b0; bus.mem_ready = 1'b0; bus.instr = '0;
    bus4.stall = 1'b0; bus4.mem_ready = 1'b0; bus4.instr = '0;
    expCount = 16'd0;
    repeat (2) @(posedge clk);

    applyStimulus("reset", 1'b0, 1'b0, 1'b0, mk(6'd0), F_WAIT);

    // R-type add
    applyStimulus("r-fetch", 0, 0, 1, mk(6'd0), F_RDY);
    applyStimulus("r-dec",   0, 0, 1, mk(6'd0), DEC);
    applyStimulus("r-exec",  0, 0, 1, mk(6'd0), EX_R);
    applyStimulus("r-wb",    0, 0, 1, mk(6'd0), WB_R);
    expCount++;

    // lw with memory slow for three cycles
    applyStimulus("lw-fetch", 0, 0, 1, mk(6'd4), F_RDY);
    applyStimulus("lw-dec",   0, 0, 1, mk(6'd4), DEC);
    applyStimulus("lw-exec",  0, 0, 1, mk(6'd4), EX_MEM);
    for (int i = 0; i < 3; i++) applyStimulus("lw-memwait", 0, 0, 0, mk(6'd4), MEM_LW);
    applyStimulus("lw-mem",   0, 0, 1, mk(6'd4), MEM_LW);
    applyStimulus("lw-wb",    0, 0, 1, mk(6'd4), WB_LW);
    expCount++;

    // sw, stalled once in MEM while memory reports ready
    applyStimulus("sw-fetch", 0, 0, 1, mk(6'd3), F_RDY);
    applyStimulus("sw-dec",   0, 0, 1, mk(6'd3), DEC);
    applyStimulus("sw-exec",  0, 0, 1, mk(6'd3), EX_MEM);
    applyStimulus("sw-stall", 0, 1, 1, mk(6'd3), MEM_HLD);
    applyStimulus("sw-mem",   0, 0, 1, mk(6'd3), MEM_SW);
    expCount++;

    applyStimulus("bne-fetch", 0, 0, 1, mk(6'd2), F_RDY);
    applyStimulus("bne-dec",   0, 0, 1, mk(6'd2), DEC);
    applyStimulus("bne-exec",  0, 0, 1, mk(6'd2), EX_BNE);
    expCount++;
    applyStimulus("beq-fetch", 0, 0, 1, mk(6'd1), F_RDY);
    applyStimulus("beq-dec",   0, 0, 1, mk(6'd1), DEC);
    applyStimulus("beq-exec",  0, 0, 1, mk(6'd1), EX_BEQ);
    expCount++;
    applyStimulus("j-fetch",   0, 0, 1, mk(6'd9), F_RDY);
    applyStimulus("j-dec",     0, 0, 1, mk(6'd9), DEC);
    applyStimulus("j-exec",    0, 0, 1, mk(6'd9), EX_J);
    expCount++;

    iOps = '{6'd5, 6'd6, 6'd7, 6'd8};
    iAlu = '{3'b000, 3'b011, 3'b100, 3'b111};
    for (int k = 0; k < 4; k++) begin
      applyStimulus("imm-fetch", 0, 0, 1, mk(iOps[k]), F_RDY);
      applyStimulus("imm-dec",   0, 0, 1, mk(iOps[k]), DEC);
      applyStimulus("imm-exec",  0, 0, 1, mk(iOps[k]), cv(3'd2, 5'b0, iAlu[k], 2'd2, 6'b0));
      applyStimulus("imm-wb",    0, 0, 1, mk(iOps[k]), WB_I);
      expCount++;
    end

    // Stall in FETCH against a ready memory, then a NOP
    applyStimulus("stall-fetch", 0, 1, 1, 32'd0, F_STALL);
    applyStimulus("stall-fetch", 0, 1, 1, 32'd0, F_STALL);
    applyStimulus("nop-fetch",   0, 0, 1, 32'd0, F_RDY);
    applyStimulus("nop-dec",     0, 0, 1, 32'd0, DEC);
    expCount++;

    // Stall holding WB of an R-type
    applyStimulus("rs-fetch", 0, 0, 1, mk(6'd0), F_RDY);
    applyStimulus("rs-dec",   0, 0, 1, mk(6'd0), DEC);
    applyStimulus("rs-exec",  0, 0, 1, mk(6'd0), EX_R);
    applyStimulus("rs-stall", 0, 1, 1, mk(6'd0), WB_RSTL);
    applyStimulus("rs-wb",    0, 0, 1, mk(6'd0), WB_R);
    expCount++;
    applyStimulus("post-r",   0, 0, 0, mk(6'd0), F_WAIT);

    // Reset in the middle of a sw memory access
    applyStimulus("swr-fetch", 0, 0, 1, mk(6'd3), F_RDY);
    applyStimulus("swr-dec",   0, 0, 1, mk(6'd3), DEC);
    applyStimulus("swr-exec",  0, 0, 0, mk(6'd3), EX_MEM);
    applyStimulus("swr-mem",   0, 0, 0, mk(6'd3), MEM_SW);
    applyStimulus("swr-rst",   1, 0, 0, mk(6'd3), MEM_SW);
    expCount = 16'd0;
    applyStimulus("swr-after", 0, 0, 0, mk(6'd3), F_WAIT);

    // Illegal opcode traps until reset
    applyStimulus("ill-fetch", 0, 0, 1, mk(6'h3F), F_RDY);
    applyStimulus("ill-dec",   0, 0, 1, mk(6'h3F), DEC);
    for (int i = 0; i < 20; i++) applyStimulus("ill-trap", 0, 0, 1, mk(6'h3F), TRAPV);
    applyStimulus("ill-rst",   1, 0, 1, mk(6'h3F), TRAPV);
    applyStimulus("ill-after", 0, 0, 0, mk(6'h3F), F_WAIT);

    // Narrow counter wraps after 16 NOPs
    @(negedge clk);
    rst4 = 1'b0; bus4.mem_ready = 1'b1; bus4.instr = 32'd0;
    repeat (32) @(posedge clk);
    #1 checkOutput("cnt4-wrap", {28'd0, bus4.instr_count}, 32'd0);
    checkOutput("cnt4-state", {29'd0, bus4.state}, 32'd0);
    repeat (2) @(posedge clk);
    #1 checkOutput("cnt4-17", {28'd0, bus4.instr_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
